run_ctrl: RTL and testbench
===========================

# run_ctrl

Run controller sequencing the CPU core through reset, run and completion. Synchronises release of the external `rst_n`, holds the core in reset for a fixed number of cycles and releases it. While the core runs, it counts cycles and ends the run on a core halt report or a watchdog timeout. It sits between the top-level clock/reset and the core, and exposes done/pass/timeout status to the simulation environment and board top.

## Interface

Parameters:
- `RST_CYCLES`, default 10: cycles the core is held in reset after synchronised release. Legal range is ≥1.
- `TIMEOUT_CYCLES`, default 1000000: run-cycle limit before watchdog expiry. Legal range is ≥1.
- `CNT_W`, default 32: width of the cycle counter.

Ports:
- `clk` input, 1 bit: single clock, rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `soft_rst_req` input, 1 bit: one-cycle request to re-run the reset sequence.
- `core_halt_vld` input, 1 bit: core reports halt this cycle.
- `core_halt_code` input, 32 bits: halt code. Zero means good trap.
- `core_rst_n` output, 1 bit: registered active-low reset to the core.
- `run_cycles` output, `CNT_W` bits: cycles spent in RUN.
- `halt_code` output, 32 bits: latched `core_halt_code`.
- `done` output, 1 bit: sticky run-complete flag.
- `pass` output, 1 bit: halted with code 0.
- `timeout` output, 1 bit: watchdog expired.

## Operation

- Reset is asynchronous active-low on one clock. When `rst_n` is low, every register clears immediately.
- Reset values: `core_rst_n`=0, `run_cycles`=0, `halt_code`=0, `done`=0, `pass`=0, `timeout`=0, state=SYNC, hold counter=0.
- Reset synchroniser:
  - 2-flop chain with asynchronous assert and synchronous deassert.
  - The FSM leaves SYNC only when the synchroniser output is 1.
- FSM states: SYNC, HOLD, RUN, DONE.
- SYNC → HOLD when the synchronised reset is high. The hold counter loads 0.
- HOLD:
  - The hold counter increments each cycle.
  - When the counter equals `RST_CYCLES-1`, the FSM moves to RUN on the next edge.
  - `core_rst_n`=0 throughout HOLD.
- RUN:
  - `core_rst_n`=1.
  - `run_cycles` increments by 1 per cycle and saturates at all-ones.
- RUN → DONE on `core_halt_vld`=1:
  - Latch `halt_code`, set `done`=1.
  - Set `pass`=(`core_halt_code`==0) and `timeout`=0.
- RUN → DONE on watchdog: when `run_cycles`==`TIMEOUT_CYCLES-1` and no halt is present, set `done`=1, `timeout`=1, `pass`=0.
- If halt and watchdog expiry occur in the same cycle, the halt wins and `timeout` stays 0.
- DONE:
  - Terminal state. `core_rst_n` stays 1.
  - Status, `run_cycles` and `halt_code` are frozen.
  - `core_halt_vld` is ignored.
- Soft reset (`soft_rst_req`=1 in HOLD, RUN or DONE):
  - On the next edge, enter HOLD with the hold counter at 0 and `core_rst_n`=0.
  - Clear `run_cycles`, `halt_code`, `done`, `pass` and `timeout`.
  - Soft reset has priority over halt and timeout in the same cycle.
  - In HOLD it restarts the count.
  - `soft_rst_req` is ignored in SYNC.

## Timing

- Let E1 be the first rising edge at which `rst_n` is sampled high.
- The synchroniser output is high after E2, and the FSM is in HOLD after E3.
- `core_rst_n` rises after edge E(3+`RST_CYCLES`). With the default of 10, this is E13.
- HOLD lasts exactly `RST_CYCLES` cycles.
- `run_cycles` equals 1 after the first edge in RUN.
- `done` asserts one edge after the cycle in which `core_halt_vld` is sampled high in RUN.
- Default timeout: `done`/`timeout` assert `TIMEOUT_CYCLES` cycles after RUN entry.
- Soft reset takes 1 edge to reach HOLD, and `core_rst_n` rises `RST_CYCLES` edges later.
- Asserting `rst_n` mid-run drops `core_rst_n` with no clock. Deasserting it replays the full SYNC/HOLD sequence.

## Configuration

- `RUN_CTRL_TIMEOUT_EN`: when defined, the watchdog is compiled in as described above.
- When undefined:
  - No watchdog comparator is built and `timeout` is tied to 0.
  - RUN exits only on halt or soft reset.
  - `TIMEOUT_CYCLES` is unused.

## Structure

- Shared package `run_ctrl_pkg` contains:
  - The state enum (`SYNC`, `HOLD`, `RUN`, `DONE`).
  - A constant for the halt-code width (32).
  - A constant for the good-trap code (0).
- One sub-module, `rst_sync_2ff`: 2-flop asynchronous-assert / synchronous-deassert synchroniser, reused elsewhere.
- The FSM, counters and status registers live in `run_ctrl`.

## Test plan

- Power-on with default `RST_CYCLES` of 10: hold `rst_n` low 3 cycles, then release → `core_rst_n`=0 through E12 and 1 after E13; all status outputs are 0.
- Halt with good code: after release, pulse `core_halt_vld` with code 0 at run cycle 5 → `done`=1, `pass`=1, `timeout`=0, `run_cycles`=5, frozen afterwards.
- Halt with bad code: code 0x0000_0001 → `done`=1, `pass`=0, `halt_code`=1.
- Watchdog with `TIMEOUT_CYCLES`=8 and no halt → `done`=`timeout`=1 exactly 8 cycles after RUN entry.
  - Variant: halt coincident with expiry → `timeout`=0, `pass` follows the halt code.
  - Variant with `RUN_CTRL_TIMEOUT_EN` undefined: no exit after 8 cycles.
- Soft reset in DONE, then again mid-HOLD at count 4 → status cleared, `core_rst_n` low, held a full 10 cycles from the last request.
- Assert `rst_n` mid-RUN (between clock edges) → `core_rst_n`, `run_cycles` and status clear immediately without a clock edge.

Source files
------------

// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: shared types and constants for the run controller.
// Holds the FSM state encoding plus the halt-code width and good-trap value.
package run_ctrl_pkg;

    // Run controller sequencing states.
    typedef enum logic [1:0] {
        SYNC = 2'd0,  // waiting for the synchronised external reset to release
        HOLD = 2'd1,  // core held in reset for RST_CYCLES cycles
        RUN  = 2'd2,  // core released and running
        DONE = 2'd3   // run finished (halt or watchdog); status frozen
    } run_state_t;

    localparam int unsigned        HALT_CODE_W    = 32;
    localparam logic [HALT_CODE_W-1:0] GOOD_TRAP_CODE = '0;

endpackage : run_ctrl_pkg

// File: rtl/run_ctrl_rst_sync.sv
// rst_sync_2ff: two-flop reset synchroniser.
// Asserts asynchronously with i_rst_n, deasserts synchronously two edges later.
module rst_sync_2ff (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_rst_sync_n
);

    logic r_meta;
    logic r_sync;

    // Shift a constant 1 through two flops; async clear on external reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= 1'b1;
            r_sync <= r_meta;
        end
    end

    assign o_rst_sync_n = r_sync;

endmodule : rst_sync_2ff

// File: rtl/run_ctrl.sv
// run_ctrl: sequences the core through reset hold, run and completion.
// Synchronises rst_n, holds the core in reset for RST_CYCLES, counts run
// cycles and ends the run on a halt report or (optionally) a watchdog.
// Optional feature macro: RUN_CTRL_TIMEOUT_EN compiles in the watchdog;
// without it `timeout` is tied low and TIMEOUT_CYCLES is unused.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int unsigned RST_CYCLES     = 10,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned CNT_W          = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   soft_rst_req,
    input  logic                   core_halt_vld,
    input  logic [HALT_CODE_W-1:0] core_halt_code,
    output logic                   core_rst_n,
    output logic [CNT_W-1:0]       run_cycles,
    output logic [HALT_CODE_W-1:0] halt_code,
    output logic                   done,
    output logic                   pass,
    output logic                   timeout
);

    localparam int unsigned HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);

    run_state_t             r_state;
    run_state_t             w_state_nxt;
    logic [HOLD_W-1:0]      r_hold_cnt;
    logic                   r_core_rst_n;
    logic [CNT_W-1:0]       r_run_cycles;
    logic [HALT_CODE_W-1:0] r_halt_code;
    logic                   r_done;
    logic                   r_pass;

    logic w_rst_sync_n;
    logic w_soft;
    logic w_halt;
    logic w_wdog;
    logic w_hold_last;
    logic w_run_sat;

    rst_sync_2ff u_rst_sync (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .o_rst_sync_n (w_rst_sync_n)
    );

    assign w_soft      = soft_rst_req && (r_state != SYNC);
    assign w_halt      = core_halt_vld && (r_state == RUN);
    assign w_hold_last = (r_hold_cnt == HOLD_LAST);
    assign w_run_sat   = &r_run_cycles;

`ifdef RUN_CTRL_TIMEOUT_EN
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic r_timeout;

    // Watchdog fires on the last allowed run cycle unless a halt arrives with it.
    assign w_wdog = (r_state == RUN) && !core_halt_vld && (r_run_cycles == WDOG_LAST);

    // Timeout flag: set on watchdog exit, cleared by soft reset, else frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timeout <= 1'b0;
        end else if (w_soft) begin
            r_timeout <= 1'b0;
        end else if (w_halt) begin
            r_timeout <= 1'b0;
        end else if (w_wdog) begin
            r_timeout <= 1'b1;
        end
    end

    assign timeout = r_timeout;
`else
    logic w_unused_timeout_cycles;

    assign w_unused_timeout_cycles = (TIMEOUT_CYCLES != 0);
    assign w_wdog  = 1'b0;
    assign timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; soft reset overrides every other exit.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SYNC: if (w_rst_sync_n) w_state_nxt = HOLD;
            HOLD: if (w_hold_last) w_state_nxt = RUN;
            RUN:  if (w_halt || w_wdog) w_state_nxt = DONE;
            DONE: w_state_nxt = DONE;
            default: w_state_nxt = SYNC;
        endcase
        if (w_soft) begin
            w_state_nxt = HOLD;
        end
    end

    // Hold counter, core reset, run counter and halt status.
    // core_rst_n is registered from the state being entered so it rises
    // on the same edge that moves HOLD into RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_cnt   <= '0;
            r_core_rst_n <= 1'b0;
            r_run_cycles <= '0;
            r_halt_code  <= '0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
        end else if (w_soft) begin
            r_hold_cnt   <= '0;
            r_core_rst_n <= 1'b0;
            r_run_cycles <= '0;
            r_halt_code  <= '0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
        end else begin
            case (r_state)
                SYNC: begin
                    r_hold_cnt   <= '0;
                    r_core_rst_n <= 1'b0;
                end
                HOLD: begin
                    r_hold_cnt   <= r_hold_cnt + 1'b1;
                    r_core_rst_n <= w_hold_last;
                end
                RUN: begin
                    r_core_rst_n <= 1'b1;
                    if (!w_run_sat) begin
                        r_run_cycles <= r_run_cycles + 1'b1;
                    end
                    if (w_halt) begin
                        r_halt_code <= core_halt_code;
                        r_done      <= 1'b1;
                        r_pass      <= (core_halt_code == GOOD_TRAP_CODE);
                    end else if (w_wdog) begin
                        r_done <= 1'b1;
                        r_pass <= 1'b0;
                    end
                end
                DONE: begin
                    r_core_rst_n <= 1'b1;
                end
                default: begin
                    r_core_rst_n <= 1'b0;
                end
            endcase
        end
    end

    assign core_rst_n = r_core_rst_n;
    assign run_cycles = r_run_cycles;
    assign halt_code  = r_halt_code;
    assign done       = r_done;
    assign pass       = r_pass;

endmodule : run_ctrl

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: directed self-checking bench for run_ctrl (RST_CYCLES=10,
// TIMEOUT_CYCLES=8). Inputs change and outputs are sampled on the falling edge.
module tb_run_ctrl;

    localparam int unsigned RST_C = 10;
    localparam int unsigned TO_C  = 8;

    logic        clk;
    logic        rst_n;
    logic        soft_rst_req;
    logic        core_halt_vld;
    logic [31:0] core_halt_code;
    logic        core_rst_n;
    logic [31:0] run_cycles;
    logic [31:0] halt_code;
    logic        done;
    logic        pass;
    logic        timeout;

    int total;
    int bad;

    run_ctrl #(
        .RST_CYCLES     (RST_C),
        .TIMEOUT_CYCLES (TO_C),
        .CNT_W          (32)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .soft_rst_req   (soft_rst_req),
        .core_halt_vld  (core_halt_vld),
        .core_halt_code (core_halt_code),
        .core_rst_n     (core_rst_n),
        .run_cycles     (run_cycles),
        .halt_code      (halt_code),
        .done           (done),
        .pass           (pass),
        .timeout        (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Soft reset from any non-SYNC state; returns right after RUN entry.
    task automatic soft_to_run();
        soft_rst_req = 1'b1;
        edges(1);
        soft_rst_req = 1'b0;
        edges(RST_C);
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        rst_n          = 1'b0;
        soft_rst_req   = 1'b0;
        core_halt_vld  = 1'b0;
        core_halt_code = '0;

        // Power-on reset values.
        edges(3);
        chk("rst_core_rst_n", 32'(core_rst_n), 32'd0);
        chk("rst_run_cycles", run_cycles, 32'd0);
        chk("rst_halt_code", halt_code, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);

        // Release: next rising edge is E1; core_rst_n low through E12, high after E13.
        rst_n = 1'b1;
        edges(3);
        chk("e3_core_rst_n", 32'(core_rst_n), 32'd0);
        edges(9);
        chk("e12_core_rst_n", 32'(core_rst_n), 32'd0);
        edges(1);
        chk("e13_core_rst_n", 32'(core_rst_n), 32'd1);
        chk("e13_run_cycles", run_cycles, 32'd0);
        chk("e13_done", 32'(done), 32'd0);
        edges(1);
        chk("run1_run_cycles", run_cycles, 32'd1);

        // Good halt sampled in the 5th run cycle.
        edges(3);
        chk("run4_run_cycles", run_cycles, 32'd4);
        core_halt_vld  = 1'b1;
        core_halt_code = 32'h0;
        edges(1);
        core_halt_vld  = 1'b0;
        chk("good_done", 32'(done), 32'd1);
        chk("good_pass", 32'(pass), 32'd1);
        chk("good_timeout", 32'(timeout), 32'd0);
        chk("good_run_cycles", run_cycles, 32'd5);
        // Frozen in DONE; a further halt report is ignored.
        core_halt_vld  = 1'b1;
        core_halt_code = 32'h5;
        edges(1);
        core_halt_vld  = 1'b0;
        edges(4);
        chk("frozen_run_cycles", run_cycles, 32'd5);
        chk("frozen_halt_code", halt_code, 32'd0);
        chk("frozen_pass", 32'(pass), 32'd1);
        chk("frozen_core_rst_n", 32'(core_rst_n), 32'd1);

        // Soft reset in DONE, then again at hold count 4.
        soft_rst_req = 1'b1;
        edges(1);
        soft_rst_req = 1'b0;
        chk("soft_core_rst_n", 32'(core_rst_n), 32'd0);
        chk("soft_done", 32'(done), 32'd0);
        chk("soft_pass", 32'(pass), 32'd0);
        chk("soft_run_cycles", run_cycles, 32'd0);
        edges(4);
        soft_rst_req = 1'b1;
        edges(1);
        soft_rst_req = 1'b0;
        edges(RST_C - 1);
        chk("soft2_hold_core_rst_n", 32'(core_rst_n), 32'd0);
        edges(1);
        chk("soft2_run_core_rst_n", 32'(core_rst_n), 32'd1);
        chk("soft2_run_cycles", run_cycles, 32'd0);

        // Bad halt code.
        edges(2);
        core_halt_vld  = 1'b1;
        core_halt_code = 32'h0000_0001;
        edges(1);
        core_halt_vld  = 1'b0;
        chk("bad_done", 32'(done), 32'd1);
        chk("bad_pass", 32'(pass), 32'd0);
        chk("bad_halt_code", halt_code, 32'd1);
        chk("bad_run_cycles", run_cycles, 32'd3);

        // Watchdog with no halt.
        soft_to_run();
        chk("wd_clr_halt_code", halt_code, 32'd0);
        edges(TO_C - 1);
        chk("wd_pre_done", 32'(done), 32'd0);
        edges(1);
`ifdef RUN_CTRL_TIMEOUT_EN
        chk("wd_done", 32'(done), 32'd1);
        chk("wd_timeout", 32'(timeout), 32'd1);
        chk("wd_pass", 32'(pass), 32'd0);
        chk("wd_run_cycles", run_cycles, 32'd8);
        edges(2);
        chk("wd_frozen_run_cycles", run_cycles, 32'd8);
`else
        chk("nowd_done", 32'(done), 32'd0);
        chk("nowd_timeout", 32'(timeout), 32'd0);
        chk("nowd_run_cycles", run_cycles, 32'd8);
        edges(2);
        chk("nowd_run_cycles2", run_cycles, 32'd10);
        chk("nowd_core_rst_n", 32'(core_rst_n), 32'd1);
`endif

        // Halt coincident with watchdog expiry: halt wins.
        soft_to_run();
        edges(TO_C - 1);
        core_halt_vld  = 1'b1;
        core_halt_code = 32'h0;
        edges(1);
        core_halt_vld  = 1'b0;
        chk("coin_done", 32'(done), 32'd1);
        chk("coin_timeout", 32'(timeout), 32'd0);
        chk("coin_pass", 32'(pass), 32'd1);
        chk("coin_run_cycles", run_cycles, 32'd8);

        // Soft reset beats a halt in the same cycle.
        soft_to_run();
        edges(2);
        soft_rst_req   = 1'b1;
        core_halt_vld  = 1'b1;
        core_halt_code = 32'h7;
        edges(1);
        soft_rst_req   = 1'b0;
        core_halt_vld  = 1'b0;
        chk("prio_done", 32'(done), 32'd0);
        chk("prio_halt_code", halt_code, 32'd0);
        chk("prio_core_rst_n", 32'(core_rst_n), 32'd0);
        edges(RST_C);
        chk("prio_rerun_core_rst_n", 32'(core_rst_n), 32'd1);

        // Asynchronous reset mid-run clears without a clock edge.
        edges(3);
        chk("async_pre_run_cycles", run_cycles, 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_core_rst_n", 32'(core_rst_n), 32'd0);
        chk("async_run_cycles", run_cycles, 32'd0);
        chk("async_done", 32'(done), 32'd0);

        // Replay from SYNC; soft reset requests during SYNC are ignored.
        edges(2);
        rst_n        = 1'b1;
        soft_rst_req = 1'b1;
        edges(2);
        soft_rst_req = 1'b0;
        edges(10);
        chk("replay_e12_core_rst_n", 32'(core_rst_n), 32'd0);
        edges(1);
        chk("replay_e13_core_rst_n", 32'(core_rst_n), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_run_ctrl
